// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, default clock frequency and the
// cycles-per-bit divide used to derive bit timing from CLK_FREQ/BAUD.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    localparam int unsigned CLK_FREQ_DEF = 50_000_000;

    // Clock cycles per serial bit.
    function automatic int unsigned cpb(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver.
//   rx_ack_i       consumer accepts the current word
//   rx_data_o      received word, stable while rx_valid_o=1
//   rx_valid_o     word available, held until acked
//   frame_err_o    stop bit sampled 0 for the current word
//   parity_err_o   parity mismatch for the current word
//   overrun_err_o  a word was overwritten before ack (sticky until ack)
//   busy_o         receiver is mid-frame
// master: the receiver; slave: the consumer.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx_ack_i;
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic                 overrun_err_o;
    logic                 busy_o;

    modport master (
        input  rx_ack_i,
        output rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_err_o, busy_o
    );

    modport slave (
        output rx_ack_i,
        input  rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_err_o, busy_o
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk   system clock
//   rst   asynchronous active-low reset; both flops load RESET_VAL
//   d_i   asynchronous input
//   q_o   synchronised output, two cycles behind d_i
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, optional parity, 1 stop bit.
// Bits are sampled mid-bit using a cycle counter of CLK_FREQ/BAUD per bit.
//   clk, rst   system clock, asynchronous active-low reset
//   rx_i       serial line, asynchronous, idle high
//   bus        consumer handshake (uart_rx_if master modport)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    uart_rx_if.master  bus
);

    localparam int unsigned CPB  = cpb(CLK_FREQ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB);
    localparam int unsigned IW   = $clog2(DATA_BITS + 1);

    uart_rx_state_e       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_s;
    logic                 rx_dly_q;  // rx_s delayed one cycle, for falling-edge detection

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            rx_dly_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            par_q    <= par_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ovr_q    <= ovr_d;
            rx_dly_q <= rx_s;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;

        if (bus.rx_ack_i && valid_q) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge, not level: a held-low line (break) cannot retrigger.
                if (rx_dly_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    ferr_d  = !rx_s;
                    perr_d  = PARITY_EN && ((^shreg_q ^ par_q) != PARITY_ODD);
                    // A same-cycle ack consumed the old word, so it is not an overrun.
                    if (valid_q && !bus.rx_ack_i) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.rx_data_o     = data_q;
    assign bus.rx_valid_o    = valid_q;
    assign bus.frame_err_o   = ferr_q;
    assign bus.parity_err_o  = perr_q;
    assign bus.overrun_err_o = ovr_q;
    assign bus.busy_o        = (state_q != IDLE);

endmodule
